// File: rtl/wb_intercon.sv
// Single-master, N-slave Wishbone classic interconnect: registered base/mask
// decode with lowest-index priority, plus decode-error and timeout-error responses.
module wb_intercon #(
  parameter int NUM_SLAVES = 6,
  parameter int ADR_W = 32,
  parameter int DAT_W = 32,
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_BASE = {
    32'h8000_0000, 32'h4000_0000, 32'h2000_0000,
    32'h1000_0000, 32'h0800_0000, 32'h0400_0000},
  parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK = {
    32'h8000_0000, 32'h4000_0000, 32'h2000_0000,
    32'h1000_0000, 32'h0800_0000, 32'h0400_0000},
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADR_W-1:0]            m_adr_i,
  input  logic [DAT_W-1:0]            m_dat_i,
  output logic [DAT_W-1:0]            m_dat_o,
  input  logic                        m_we_i,
  input  logic [DAT_W/8-1:0]          m_sel_i,
  input  logic                        m_stb_i,
  input  logic                        m_cyc_i,
  output logic                        m_ack_o,
  output logic                        m_err_o,
  output logic [ADR_W-1:0]            s_adr_o,
  output logic [DAT_W-1:0]            s_dat_o,
  output logic                        s_we_o,
  output logic [DAT_W/8-1:0]          s_sel_o,
  output logic [NUM_SLAVES-1:0]       s_cyc_o,
  output logic [NUM_SLAVES-1:0]       s_stb_o,
  input  logic [NUM_SLAVES-1:0]       s_ack_i,
  input  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i,
  output logic                        dec_err_o,
  output logic                        tmo_err_o
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t            state;
  logic [IDX_W-1:0]  sel_r;
  logic [CNT_W-1:0]  cnt;
  logic              err_reg;
  logic              dec_reg;
  logic              tmo_reg;

  logic [NUM_SLAVES-1:0] match;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic [IDX_W-1:0]      hit_idx;
  logic                  hit;
  logic                  busy;
  logic                  sel_ack;
  logic [DAT_W-1:0]      sel_dat;

  // Per-slave address match and one-hot view of the latched selection.
  generate
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
      assign match[gi]  = (m_adr_i & SLAVE_MASK[gi*ADR_W +: ADR_W]) == SLAVE_BASE[gi*ADR_W +: ADR_W];
      assign sel_oh[gi] = (sel_r == IDX_W'(gi));
    end
  endgenerate

  // Scan downwards so the lowest matching index wins.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = IDX_W'(i);
    end
  end

  assign hit = |match;

  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_dat = sel_dat | (s_dat_i[i*DAT_W +: DAT_W] & {DAT_W{sel_oh[i]}});
    end
  end

  assign busy    = (state == BUSY);
  assign sel_ack = |(s_ack_i & sel_oh);

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_we_o  = m_we_i;
  assign s_sel_o = m_sel_i;
  assign s_cyc_o = busy ? (sel_oh & {NUM_SLAVES{m_cyc_i}}) : '0;
  assign s_stb_o = busy ? (sel_oh & {NUM_SLAVES{m_stb_i}}) : '0;

  // Ack and read data pass straight through from the selected slave, only while BUSY.
  assign m_ack_o   = busy & sel_ack;
  assign m_dat_o   = busy ? sel_dat : '0;
  assign m_err_o   = err_reg;
  assign dec_err_o = dec_reg;
  assign tmo_err_o = tmo_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sel_r   <= '0;
      cnt     <= '0;
      err_reg <= 1'b0;
      dec_reg <= 1'b0;
      tmo_reg <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      dec_reg <= 1'b0;
      tmo_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (m_cyc_i && m_stb_i) begin
            if (hit) begin
              sel_r <= hit_idx;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              state   <= ERR;
              err_reg <= 1'b1;
              dec_reg <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!m_cyc_i || sel_ack) begin
            state <= IDLE;
          end else if (TMO_EN && (cnt == TMO_LAST)) begin
            state   <= ERR;
            err_reg <= 1'b1;
            tmo_reg <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_intercon.sv
// Scoreboard bench for wb_intercon: a wait-state slave model answers the
// selected port, expected responses are queued at issue and popped on ack/err.
module tb_wb_intercon;

  localparam int NS  = 6;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [AW-1:0]  m_adr_i;
  logic [DW-1:0]  m_dat_i;
  logic [DW-1:0]  m_dat_o;
  logic           m_we_i;
  logic [3:0]     m_sel_i;
  logic           m_stb_i;
  logic           m_cyc_i;
  logic           m_ack_o;
  logic           m_err_o;
  logic [AW-1:0]  s_adr_o;
  logic [DW-1:0]  s_dat_o;
  logic           s_we_o;
  logic [3:0]     s_sel_o;
  logic [NS-1:0]  s_cyc_o;
  logic [NS-1:0]  s_stb_o;
  logic [NS-1:0]  s_ack_i;
  logic [NS*DW-1:0] s_dat_i;
  logic           dec_err_o;
  logic           tmo_err_o;

  wb_intercon #(
    .NUM_SLAVES(NS), .ADR_W(AW), .DAT_W(DW),
    .TIMEOUT_CYC(TMO), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o),
    .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_stb_i(m_stb_i), .m_cyc_i(m_cyc_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
    .dec_err_o(dec_err_o), .tmo_err_o(tmo_err_o)
  );

  always #5 clk = ~clk;

  // Bench copy of the address map (slave 0 first).
  logic [31:0] base_tab [NS] = '{32'h0400_0000, 32'h0800_0000, 32'h1000_0000,
                                 32'h2000_0000, 32'h4000_0000, 32'h8000_0000};
  logic [31:0] mask_tab [NS] = '{32'h0400_0000, 32'h0800_0000, 32'h1000_0000,
                                 32'h2000_0000, 32'h4000_0000, 32'h8000_0000};

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: each slave acks after wait_cfg wait states; spur injects stray acks.
  logic [7:0]    wait_cfg [NS];
  logic [7:0]    wcnt [NS];
  logic [NS-1:0] spur;

  generate
    for (genvar gi = 0; gi < NS; gi++) begin : g_sdat
      assign s_dat_i[gi*DW +: DW] = 32'hA5A5_0000 | 32'(gi);
    end
  endgenerate

  always_comb begin
    s_ack_i = spur;
    for (int i = 0; i < NS; i++) begin
      if (s_cyc_o[i] && s_stb_o[i] && (wcnt[i] == wait_cfg[i])) s_ack_i[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (rst) wcnt[i] <= 8'd0;
      else if (s_cyc_o[i] && s_stb_o[i] && !s_ack_i[i]) wcnt[i] <= wcnt[i] + 8'd1;
      else wcnt[i] <= 8'd0;
    end
  end

  typedef struct {
    logic        is_err;
    logic [31:0] dat;
  } exp_t;
  exp_t sb[$];

  // Response monitor: every ack/err must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (m_ack_o || m_err_o)) begin
      check("ack_err_excl", 64'(m_ack_o & m_err_o), 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'({m_ack_o, m_err_o}), 64'd0);
      end else begin
        e = sb.pop_front();
        check("resp_kind", 64'(m_err_o), 64'(e.is_err));
        if (e.is_err) check("err_rdata", 64'(m_dat_o), 64'd0);
        else          check("rdata", 64'(m_dat_o), 64'(e.dat));
      end
    end
  end

  function automatic int model_sel(input logic [31:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & mask_tab[i]) == base_tab[i]) return i;
    end
    return -1;
  endfunction

  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wd,
                      input logic [3:0] sel, input int waits, input int spur_n,
                      input logic [NS-1:0] spur_mask);
    int idx, exp_lat, exp_cyc, n, hi;
    bit is_dec, is_tmo, done, bad;
    logic dec_seen, tmo_seen;
    logic [NS-1:0] oh;
    exp_t e;
    idx    = model_sel(adr);
    is_dec = (idx < 0);
    is_tmo = !is_dec && (waits >= TMO);
    oh     = is_dec ? '0 : NS'(1) << idx;
    exp_lat = is_dec ? 1 : (is_tmo ? TMO + 1 : waits + 1);
    exp_cyc = is_dec ? 0 : (is_tmo ? TMO : waits + 1);
    e.is_err = is_dec || is_tmo;
    e.dat    = is_dec ? 32'd0 : (32'hA5A5_0000 | 32'(idx));
    sb.push_back(e);
    for (int i = 0; i < NS; i++) wait_cfg[i] = 8'(waits);
    m_adr_i = adr; m_we_i = we; m_dat_i = wd; m_sel_i = sel;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    n = 0; hi = 0; done = 0; bad = 0; dec_seen = 0; tmo_seen = 0;
    while (!done && n < 40) begin
      n++;
      @(posedge clk); #1;
      spur = (n == spur_n) ? spur_mask : '0;
      @(negedge clk);
      if (s_cyc_o != '0) begin
        hi++;
        if (s_cyc_o !== oh || s_stb_o !== oh) bad = 1;
        if (s_adr_o !== adr || s_dat_o !== wd || s_we_o !== we || s_sel_o !== sel) bad = 1;
      end
      if (m_ack_o || m_err_o) begin
        done = 1; dec_seen = dec_err_o; tmo_seen = tmo_err_o;
      end
    end
    @(posedge clk); #1;
    spur = '0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    check("latency", 64'(n), 64'(exp_lat));
    check("cyc_cycles", 64'(hi), 64'(exp_cyc));
    check("bus_shape", 64'(bad), 64'd0);
    check("dec_err", 64'(dec_seen), 64'(is_dec));
    check("tmo_err", 64'(tmo_seen), 64'(is_tmo));
    $display("xfer adr=%08h we=%0d slave=%0d waits=%0d latency=%0d cyc_cycles=%0d", adr, we, idx, waits, n, hi);
  endtask

  // Start a request that never gets acked, then kill it with cyc drop or reset.
  task automatic abort_xfer(input bit use_rst);
    logic [3:0] flags;
    for (int i = 0; i < NS; i++) wait_cfg[i] = 8'd255;
    m_adr_i = 32'h8000_0010; m_we_i = 1'b0; m_dat_i = '0; m_sel_i = 4'hF;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check(use_rst ? "rst_busy_cyc" : "abort_busy_cyc", 64'(s_cyc_o), 64'(6'b100000));
    @(posedge clk); #1;
    if (use_rst) rst = 1'b1;
    else begin m_cyc_i = 1'b0; m_stb_i = 1'b0; end
    @(posedge clk); #1;
    rst = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
    check(use_rst ? "rst_strobes" : "abort_strobes", 64'({s_cyc_o, s_stb_o}), 64'd0);
    flags = '0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      flags = flags | {m_ack_o, m_err_o, dec_err_o, tmo_err_o};
    end
    check(use_rst ? "rst_no_resp" : "abort_no_resp", 64'(flags), 64'd0);
    $display("abort via %s: strobes=%0h flags=%0h", use_rst ? "rst" : "cyc drop", {s_cyc_o, s_stb_o}, flags);
  endtask

  logic [31:0] rnd_adr [7] = '{32'h0400_0010, 32'h0800_0020, 32'h1000_0004, 32'h2000_0030,
                               32'h4000_0040, 32'hFFFF_FFFF, 32'h0000_1000};

  initial begin
    rst = 1'b1; spur = '0;
    m_adr_i = 32'h2000_0004; m_dat_i = '0; m_we_i = 1'b0; m_sel_i = 4'hF;
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    for (int i = 0; i < NS; i++) wait_cfg[i] = 8'd0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_outputs", 64'({s_cyc_o, s_stb_o, m_ack_o, m_err_o, dec_err_o, tmo_err_o, m_dat_o}), 64'd0);
      $display("reset cycle %0d: outputs=%0h", k, {s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_dat_o});
    end
    @(posedge clk); #1;
    rst = 1'b0; m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(posedge clk); #1;

    xfer(32'h2000_0004, 1'b0, 32'h0, 4'hF, 0, 0, '0);                    // zero-wait read, slave 3
    xfer(32'h8000_0010, 1'b1, 32'h1234_5678, 4'hF, 3, 2, 6'b000010);     // 3 waits, stray ack on slave 1
    xfer(32'h0000_0100, 1'b0, 32'h0, 4'hF, 0, 0, '0);                    // decode error
    xfer(32'hC000_0000, 1'b0, 32'h0, 4'hF, 1, 0, '0);                    // overlap: slave 4 wins
    xfer(32'h0400_0000, 1'b0, 32'h0, 4'hF, 255, TMO + 1, 6'b000001);     // timeout, late ack in ERR
    abort_xfer(1'b0);
    abort_xfer(1'b1);
    xfer(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'h3, 1, 0, '0);            // normal after reset

    for (int k = 0; k < 8; k++) begin
      xfer(rnd_adr[$urandom_range(6, 0)], 1'($urandom_range(1, 0)), $urandom,
           4'($urandom_range(15, 1)), int'($urandom_range(2, 0)), 0, '0);
    end

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
